// File: rtl/op_sequencer.sv
// op_sequencer: six-state control sequencer issuing load/select strobes for a two-operand ALU datapath
module op_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             E,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [1:0]       src1,
  input  logic [1:0]       src2,
  input  logic [1:0]       dst,
  output logic             ready,
  output logic             done,
  output logic [1:0]       T,
  output logic             LD_R1,
  output logic             LD_R2,
  output logic             LD_R3,
  output logic             LD_DR1,
  output logic             LD_DR2,
  output logic             LD_AC,
  output logic             LD_outr,
  output logic [2:0]       sel_A,
  output logic             sel_B,
  output logic [1:0]       alu_op,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [2:0] {IDLE, LD1, LD2, EXEC, WB, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] op_q, src1_q, src2_q, dst_q;
  function automatic logic [2:0] enc(input logic [1:0] s);
    return s == 2'd0 ? 3'b100 : {1'b0, s};
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      dst_q    <= '0;
      op_count <= '0;
    end else if (E) begin
      state <= state_nx;
      if (state == IDLE && start) begin
        op_q   <= op;
        src1_q <= src1;
        src2_q <= src2;
        dst_q  <= dst;
      end
      if (state == DONE) op_count <= op_count + 1'b1;
    end
  end
  always_comb begin
    state_nx = state == IDLE ? (start ? LD1 : IDLE) :
               state == LD1  ? LD2  :
               state == LD2  ? EXEC :
               state == EXEC ? WB   :
               state == WB   ? DONE : IDLE;
    ready    = state == IDLE;
    T        = state == LD2 ? 2'd1 : state == EXEC ? 2'd2 : state == WB ? 2'd3 : 2'd0;
    sel_A    = state == LD1 ? enc(src1_q) : state == LD2 ? enc(src2_q) : state == WB ? 3'b100 : 3'b000;
    alu_op   = op_q;
    LD_DR1   = E && state == LD1;
    LD_DR2   = E && state == LD2;
    LD_AC    = E && state == EXEC;
    sel_B    = E && state == WB;
    LD_outr  = E && state == WB && dst_q == 2'd0;
    LD_R1    = E && state == WB && dst_q == 2'd1;
    LD_R2    = E && state == WB && dst_q == 2'd2;
    LD_R3    = E && state == WB && dst_q == 2'd3;
    done     = E && state == DONE;
  end
endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer: directed self-checking bench for op_sequencer
module tb_op_sequencer;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst, E, start;
  logic [1:0] op, src1, src2, dst;
  logic ready, done, LD_R1, LD_R2, LD_R3, LD_DR1, LD_DR2, LD_AC, LD_outr, sel_B;
  logic [1:0] T, alu_op;
  logic [2:0] sel_A;
  logic [CNT_W-1:0] op_count;
  logic [6:0] ld;
  int checks = 0;
  int errors = 0;
  op_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .E(E), .start(start), .op(op), .src1(src1), .src2(src2), .dst(dst),
    .ready(ready), .done(done), .T(T), .LD_R1(LD_R1), .LD_R2(LD_R2), .LD_R3(LD_R3),
    .LD_DR1(LD_DR1), .LD_DR2(LD_DR2), .LD_AC(LD_AC), .LD_outr(LD_outr),
    .sel_A(sel_A), .sel_B(sel_B), .alu_op(alu_op), .op_count(op_count)
  );
  always #5 clk = ~clk;
  assign ld = {LD_DR1, LD_DR2, LD_AC, LD_R1, LD_R2, LD_R3, LD_outr};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic exp_cyc(input string tag, input logic [6:0] l, input logic [2:0] a, input logic b,
                         input logic [1:0] t, input logic d, input logic r);
    chk(tag, {17'd0, ld, sel_A, sel_B, T, done, ready}, {17'd0, l, a, b, t, d, r});
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic run_op(input string tag, input logic [1:0] o, input logic [1:0] s1, input logic [1:0] s2,
                        input logic [1:0] d, input logic [2:0] a1, input logic [2:0] a2,
                        input logic [6:0] lwb, input logic [CNT_W-1:0] cnt);
    op = o; src1 = s1; src2 = s2; dst = d; start = 1'b1;
    tick; start = 1'b0;
    exp_cyc({tag, "/ld1"}, 7'h40, a1, 1'b0, 2'd0, 1'b0, 1'b0);
    tick; exp_cyc({tag, "/ld2"}, 7'h20, a2, 1'b0, 2'd1, 1'b0, 1'b0);
    tick; exp_cyc({tag, "/exec"}, 7'h10, 3'b000, 1'b0, 2'd2, 1'b0, 1'b0);
    chk({tag, "/alu_op"}, alu_op, o);
    tick; exp_cyc({tag, "/wb"}, lwb, 3'b100, 1'b1, 2'd3, 1'b0, 1'b0);
    tick; exp_cyc({tag, "/done"}, 7'h00, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0);
    tick; exp_cyc({tag, "/idle"}, 7'h00, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1);
    chk({tag, "/count"}, op_count, cnt);
  endtask
  initial begin
    rst = 1'b1; E = 1'b1; start = 1'b0; op = 2'd0; src1 = 2'd0; src2 = 2'd0; dst = 2'd0;
    tick;
    exp_cyc("reset", 7'h00, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("reset/count", op_count, 0);
    chk("reset/alu_op", alu_op, 0);
    rst = 1'b0;
    tick; exp_cyc("idle_no_start", 7'h00, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1);
    E = 1'b0; start = 1'b1; op = 2'd2;
    tick; exp_cyc("idle_e_low", 7'h00, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("idle_e_low/alu_op", alu_op, 0);
    E = 1'b1; start = 1'b0;
    run_op("add_r3", 2'd0, 2'd1, 2'd2, 2'd3, 3'b001, 3'b010, 7'h02, 4'd1);
    run_op("sub_ac", 2'd1, 2'd0, 2'd0, 2'd0, 3'b100, 3'b100, 7'h01, 4'd2);
    run_op("and_same", 2'd2, 2'd3, 2'd3, 2'd3, 3'b011, 3'b011, 7'h02, 4'd3);
    run_op("pass_r1", 2'd3, 2'd2, 2'd1, 2'd1, 3'b010, 3'b001, 7'h08, 4'd4);
    run_op("add_r2", 2'd0, 2'd3, 2'd0, 2'd2, 3'b011, 3'b100, 7'h04, 4'd5);
    op = 2'd2; src1 = 2'd1; src2 = 2'd2; dst = 2'd2; start = 1'b1;
    tick; start = 1'b0;
    tick;
    tick; exp_cyc("stall/exec", 7'h10, 3'b000, 1'b0, 2'd2, 1'b0, 1'b0);
    E = 1'b0; #1;
    exp_cyc("stall/e_drop", 7'h00, 3'b000, 1'b0, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick;
      exp_cyc("stall/held", 7'h00, 3'b000, 1'b0, 2'd2, 1'b0, 1'b0);
      chk("stall/count", op_count, 5);
    end
    E = 1'b1; #1;
    exp_cyc("stall/resume", 7'h10, 3'b000, 1'b0, 2'd2, 1'b0, 1'b0);
    tick; exp_cyc("stall/wb", 7'h04, 3'b100, 1'b1, 2'd3, 1'b0, 1'b0);
    E = 1'b0; #1;
    exp_cyc("stall/wb_gated", 7'h00, 3'b100, 1'b0, 2'd3, 1'b0, 1'b0);
    E = 1'b1;
    tick; exp_cyc("stall/done", 7'h00, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0);
    tick; chk("stall/count_after", op_count, 6);
    op = 2'd0; src1 = 2'd1; src2 = 2'd2; dst = 2'd1; start = 1'b1;
    tick; exp_cyc("b2b/ld1", 7'h40, 3'b001, 1'b0, 2'd0, 1'b0, 1'b0);
    op = 2'd3; src1 = 2'd3; src2 = 2'd3; dst = 2'd3;
    tick; exp_cyc("b2b/ld2", 7'h20, 3'b010, 1'b0, 2'd1, 1'b0, 1'b0);
    tick; chk("b2b/alu_op", alu_op, 0);
    tick; exp_cyc("b2b/wb", 7'h08, 3'b100, 1'b1, 2'd3, 1'b0, 1'b0);
    tick; exp_cyc("b2b/done", 7'h00, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0);
    tick; exp_cyc("b2b/idle", 7'h00, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("b2b/alu_held", alu_op, 0);
    chk("b2b/count1", op_count, 7);
    tick; exp_cyc("b2b/ld1_next", 7'h40, 3'b011, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("b2b/alu_next", alu_op, 3);
    start = 1'b0;
    tick; tick; tick; exp_cyc("b2b/wb_next", 7'h02, 3'b100, 1'b1, 2'd3, 1'b0, 1'b0);
    tick; tick; chk("b2b/count2", op_count, 8);
    op = 2'd1; src1 = 2'd1; src2 = 2'd1; dst = 2'd2; start = 1'b1;
    tick; start = 1'b0;
    tick; tick; tick; exp_cyc("rst_wb/wb", 7'h04, 3'b100, 1'b1, 2'd3, 1'b0, 1'b0);
    rst = 1'b1; #1;
    exp_cyc("rst_wb/now", 7'h00, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("rst_wb/count", op_count, 0);
    chk("rst_wb/alu_op", alu_op, 0);
    tick; exp_cyc("rst_wb/held", 7'h00, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1);
    rst = 1'b0;
    run_op("post_rst", 2'd2, 2'd2, 2'd3, 2'd1, 3'b010, 3'b011, 7'h08, 4'd1);
    for (int i = 2; i <= 17; i++)
      run_op("wrap", 2'(i), 2'd1, 2'd2, 2'd0, 3'b001, 3'b010, 7'h01, 4'(i));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/op_sequencer.md
OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, width of the completed-operation counter.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port E  input  1  global enable; low freezes all state and gates all strobes.
REQ-005 The block SHALL have port start  input  1  request to run one operation; sampled only in IDLE.
REQ-006 The block SHALL have port op  input  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 PASS (DR1).
REQ-007 The block SHALL have port src1, src2  input  2 each  operand source: 00 AC, 01 R1, 10 R2, 11 R3.
REQ-008 The block SHALL have port dst  input  2  destination: 00 outr, 01 R1, 10 R2, 11 R3.
REQ-009 The block SHALL have port ready  output  1  high only in IDLE.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse on completion.
REQ-011 The block SHALL have port T  output  2  phase index of the active operation.
REQ-012 The block SHALL have ports LD_R1, LD_R2, LD_R3, LD_DR1, LD_DR2, LD_AC, LD_outr  output  1 each  datapath load strobes.
REQ-013 The block SHALL have port sel_A  output  3  bus source: 000 none, 001 R1, 010 R2, 011 R3, 100 AC.
REQ-014 The block SHALL have port sel_B  output  1  1 selects ALU result onto the write-back path.
REQ-015 The block SHALL have port alu_op  output  2  ALU operation to the datapath.
REQ-016 The block SHALL have port op_count  output  CNT_W  number of completed operations.

Function
REQ-017 FSM states SHALL be IDLE, LD1, LD2, EXEC, WB, DONE.
REQ-018 In IDLE with E=1 and start=1, op/src1/src2/dst SHALL be latched and the FSM SHALL enter LD1 at the next edge; start=0 stays in IDLE.
REQ-019 The sequence SHALL be LD1 -> LD2 -> EXEC -> WB -> DONE -> IDLE, one state per enabled cycle; start SHALL be ignored outside IDLE.
REQ-020 T SHALL be 0 in LD1, 1 in LD2, 2 in EXEC, 3 in WB, and 0 in IDLE and DONE.
REQ-021 LD1: sel_A SHALL encode latched src1 (00 -> 100, else {1'b0,src1}), LD_DR1=1.
REQ-022 LD2: sel_A SHALL encode latched src2 by the same mapping, LD_DR2=1.
REQ-023 EXEC: alu_op SHALL equal latched op, LD_AC=1, sel_A=000.
REQ-024 WB: sel_A=100, sel_B=1, exactly one of LD_outr/LD_R1/LD_R2/LD_R3 SHALL be high per latched dst.
REQ-025 DONE: done=1 for that cycle; op_count SHALL increment by 1 modulo 2^CNT_W (wrap from all-ones to 0).
REQ-026 Outside the states listed, every LD_* strobe, sel_B, and done SHALL be 0, and sel_A SHALL be 000; alu_op SHALL hold the latched op at all times.
REQ-027 At most one LD_* strobe SHALL be high in any cycle.
REQ-028 With E=0, state, latches, T and op_count SHALL hold; all LD_* strobes, done and sel_B SHALL be 0; E returning high resumes from the held state.
REQ-029 Latency: start accepted at edge N -> LD_DR1 during cycle N..N+1, done during the fifth enabled cycle after acceptance, ready again the cycle after done.
REQ-030 src1=src2 and src=dst SHALL be legal and follow the same sequence unchanged.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, ready=1, T=0, done=0, all LD_*=0, sel_A=000, sel_B=0, alu_op=00, latched fields=0, op_count=0, including mid-operation.
REQ-032 After rst falls, the first start SHALL be accepted at the first rising edge with E=1.

Verification
REQ-033 After reset, start with op=00, src1=01, src2=10, dst=11, E=1 -> LD_DR1 (sel_A=001), LD_DR2 (sel_A=010), LD_AC (alu_op=00), LD_R3 (sel_A=100, sel_B=1), done, op_count=1.
REQ-034 op=01, src1=00, src2=00, dst=00 -> sel_A=100 in LD1 and LD2, LD_outr in WB; T sequence 0,1,2,3.
REQ-035 E=0 held 3 cycles during EXEC -> LD_AC low and T=2 throughout; EXEC completes after E returns; done 3 cycles later than nominal.
REQ-036 start held high continuously with new operands mid-operation -> operands unchanged until IDLE; back-to-back ops complete every 6 cycles.
REQ-037 rst asserted during WB -> LD_* low at once, ready=1, op_count=0, no done pulse.
REQ-038 2^CNT_W+1 operations (17 at default) -> op_count wraps through 0 and reads 1.
